// File: rtl/mac_tx.sv
// Ethernet MAC transmit path. Wraps an upper-layer frame with preamble/SFD,
// pads to the 60-byte minimum, appends the CRC-32 FCS and enforces the
// inter-packet gap. All PCS-side outputs are registered.
module mac_tx #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [KEEP_W-1:0] keep_i,
    input  logic              last_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              ctrl_v_o,
    output logic              start_o,
    output logic              term_o,
    output logic [KEEP_W-1:0] term_keep_o,
    output logic              idle_o,
    output logic              err_o
);

    localparam int unsigned PreBeats = 8 / KEEP_W;
    localparam int unsigned IpgBeats = 12 / KEEP_W;
    localparam int unsigned MinLen   = 60;
    localparam logic [31:0] CrcInit  = 32'hFFFF_FFFF;

    typedef enum logic [5:0] {
        StIdle = 6'b000001,
        StPre  = 6'b000010,
        StData = 6'b000100,
        StPad  = 6'b001000,
        StFcs  = 6'b010000,
        StIpg  = 6'b100000
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        pre_cnt_q, pre_cnt_d;
    logic [3:0]        ipg_cnt_q, ipg_cnt_d;
    logic [2:0]        fcs_idx_q, fcs_idx_d;   // FCS bytes already sent
    logic [5:0]        count_q, count_d;       // frame bytes, saturating at 60
    logic [31:0]       crc_q, crc_d;
    logic              drain_q, drain_d;       // dropping the tail of an underrun frame

    logic [DATA_W-1:0] data_q, data_d;
    logic              ctrl_v_q, ctrl_v_d;
    logic              start_q, start_d;
    logic              term_q, term_d;
    logic [KEEP_W-1:0] keep_q, keep_d;
    logic              idle_q, idle_d;
    logic              err_q, err_d;
    logic              valid_q;

    logic [KEEP_W-1:0] keep_eff;
    logic [3:0]        pop;
    logic [6:0]        total;
    logic [DATA_W-1:0] data_msk;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] fcs_data;
    logic [KEEP_W-1:0] fcs_keep;
    logic [31:0]       crc_dat, crc_full, crc_zero, fcs_now;

    // Reflected CRC-32 over one byte.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] crc_beat(input logic [31:0] c, input logic [DATA_W-1:0] d,
                                             input logic [KEEP_W-1:0] en);
        logic [31:0] r;
        r = c;
        for (int j = 0; j < KEEP_W; j++) begin
            if (en[j]) r = crc_byte(r, d[8*j +: 8]);
        end
        return r;
    endfunction

    // Preamble beat b: bytes 0..6 are 0x55, byte 7 is the SFD.
    function automatic logic [DATA_W-1:0] pre_beat(input logic [1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int j = 0; j < KEEP_W; j++) begin
            r[8*j +: 8] = (int'(b) * KEEP_W + j == 7) ? 8'hD5 : 8'h55;
        end
        return r;
    endfunction

    assign keep_eff = last_i ? keep_i : '1;
    assign total    = {1'b0, count_q} + {3'b0, pop};
    assign crc_dat  = crc_beat(crc_q, data_i, keep_eff);
    assign crc_full = crc_beat(crc_q, data_msk, '1);
    assign crc_zero = crc_beat(crc_q, '0, '1);
    assign fcs_now  = ~crc_dat;
    assign ready_o  = (state_q == StData) || drain_q;

    // Beat helpers: enabled-byte count, zero-masked data, FCS merged after data.
    always_comb begin
        pop      = '0;
        data_msk = '0;
        merged   = '0;
        for (int j = 0; j < KEEP_W; j++) begin
            pop = pop + 4'(keep_eff[j]);
        end
        for (int j = 0; j < KEEP_W; j++) begin
            if (keep_eff[j]) data_msk[8*j +: 8] = data_i[8*j +: 8];
            if (j < int'(pop)) merged[8*j +: 8] = data_i[8*j +: 8];
            else merged[8*j +: 8] = 8'(fcs_now >> (8 * (j - int'(pop))));
        end
    end

    // Remaining FCS bytes, LSB first, starting at fcs_idx_q.
    always_comb begin
        fcs_data = '0;
        fcs_keep = '0;
        for (int j = 0; j < KEEP_W; j++) begin
            if (int'(fcs_idx_q) + j < 4) begin
                fcs_data[8*j +: 8] = 8'(~crc_q >> (8 * (int'(fcs_idx_q) + j)));
                fcs_keep[j] = 1'b1;
            end
        end
    end

    // Next-state and next-output-beat logic.
    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        ipg_cnt_d = ipg_cnt_q;
        fcs_idx_d = fcs_idx_q;
        count_d   = count_q;
        crc_d     = crc_q;
        drain_d   = drain_q;
        data_d    = '0;
        ctrl_v_d  = 1'b0;
        start_d   = 1'b0;
        term_d    = 1'b0;
        keep_d    = '0;
        idle_d    = 1'b0;
        err_d     = 1'b0;

        if (drain_q && valid_i && last_i) drain_d = 1'b0;

        unique case (state_q)
            StIdle, StIpg: begin
                if (state_q == StIpg && ipg_cnt_q < 4'(IpgBeats)) begin
                    idle_d    = 1'b1;
                    ctrl_v_d  = 1'b1;
                    ipg_cnt_d = ipg_cnt_q + 4'd1;
                end else if (valid_i && !drain_q) begin
                    // First preamble beat leaves straight from idle/gap.
                    data_d    = pre_beat(2'd0);
                    ctrl_v_d  = 1'b1;
                    start_d   = 1'b1;
                    pre_cnt_d = 2'd1;
                    crc_d     = CrcInit;
                    count_d   = '0;
                    state_d   = StPre;
                end else begin
                    idle_d   = 1'b1;
                    ctrl_v_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            StPre: begin
                data_d    = pre_beat(pre_cnt_q);
                pre_cnt_d = pre_cnt_q + 2'd1;
                if (pre_cnt_q == 2'(PreBeats - 1)) state_d = StData;
            end
            StData: begin
                if (!valid_i) begin
                    // Underrun: abort with an errored zero-byte term.
                    err_d     = 1'b1;
                    ctrl_v_d  = 1'b1;
                    term_d    = 1'b1;
                    crc_d     = CrcInit;
                    count_d   = '0;
                    ipg_cnt_d = '0;
                    drain_d   = 1'b1;
                    state_d   = StIpg;
                end else if (!last_i) begin
                    data_d  = data_i;
                    crc_d   = crc_dat;
                    count_d = (total > 7'(MinLen)) ? 6'(MinLen) : total[5:0];
                end else if (total < 7'(MinLen)) begin
                    // Short frame: the rest of this beat becomes pad.
                    data_d    = data_msk;
                    crc_d     = crc_full;
                    count_d   = count_q + 6'(KEEP_W);
                    fcs_idx_d = '0;
                    state_d   = (count_q + 6'(KEEP_W) == 6'(MinLen)) ? StFcs : StPad;
                end else begin
                    data_d    = merged;
                    crc_d     = crc_dat;
                    count_d   = (total > 7'(MinLen)) ? 6'(MinLen) : total[5:0];
                    fcs_idx_d = (pop == 4'(KEEP_W)) ? 3'd0 : 3'(4'(KEEP_W) - pop);
                    state_d   = StFcs;
                end
            end
            StPad: begin
                crc_d     = crc_zero;
                count_d   = count_q + 6'(KEEP_W);
                fcs_idx_d = '0;
                if (count_q + 6'(KEEP_W) == 6'(MinLen)) state_d = StFcs;
            end
            StFcs: begin
                data_d = fcs_data;
                if ({1'b0, fcs_idx_q} + 4'(KEEP_W) >= 4'd4) begin
                    term_d    = 1'b1;
                    ctrl_v_d  = 1'b1;
                    keep_d    = fcs_keep;
                    ipg_cnt_d = '0;
                    state_d   = StIpg;
                end else begin
                    fcs_idx_d = fcs_idx_q + 3'(KEEP_W);
                end
            end
            default: begin
                idle_d   = 1'b1;
                ctrl_v_d = 1'b1;
                state_d  = StIdle;
            end
        endcase
    end

    // State, counters, CRC and registered PCS outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pre_cnt_q <= '0;
            ipg_cnt_q <= '0;
            fcs_idx_q <= '0;
            count_q   <= '0;
            crc_q     <= CrcInit;
            drain_q   <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            ctrl_v_q  <= 1'b1;
            start_q   <= 1'b0;
            term_q    <= 1'b0;
            keep_q    <= '0;
            idle_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            ipg_cnt_q <= ipg_cnt_d;
            fcs_idx_q <= fcs_idx_d;
            count_q   <= count_d;
            crc_q     <= crc_d;
            drain_q   <= drain_d;
            valid_q   <= 1'b1;
            data_q    <= data_d;
            ctrl_v_q  <= ctrl_v_d;
            start_q   <= start_d;
            term_q    <= term_d;
            keep_q    <= keep_d;
            idle_q    <= idle_d;
            err_q     <= err_d;
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign ctrl_v_o    = ctrl_v_q;
    assign start_o     = start_q;
    assign term_o      = term_q;
    assign term_keep_o = keep_q;
    assign idle_o      = idle_q;
    assign err_o       = err_q;

endmodule
